// File: rtl/agex_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for AGEX: shift-add multiply, restoring divide,
// BITS_PER_CYCLE steps per clock, result and tag returned through a valid/ready handshake.
module agex_muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_W          = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  // state | meaning
  // IDLE  | ready for an op;  CALC | iterating;  DONE | result held until taken
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_op;
  logic                r_neg;
  logic [XLEN-1:0]     r_d;
  logic [2*XLEN-1:0]   r_acc;
  logic [CW-1:0]       r_cnt;
  logic [XLEN-1:0]     r_result;
  logic [TAG_W-1:0]    r_tag;

  logic                w_sgn1, w_sgn2, w_neg1, w_neg2, w_res_neg;
  logic [XLEN-1:0]     w_abs1, w_abs2, w_special_val;
  logic                w_div0, w_ovf, w_special, w_accept;
  logic [2*XLEN-1:0]   w_acc_nxt, w_prod;
  logic [XLEN-1:0]     w_result;

  assign w_sgn1    = in_op[2] ? ~in_op[0] : (in_op[1:0] == 2'b01 || in_op[1:0] == 2'b10);
  assign w_sgn2    = in_op[2] ? ~in_op[0] : (in_op[1:0] == 2'b01);
  assign w_neg1    = w_sgn1 & in_rs1[XLEN-1];
  assign w_neg2    = w_sgn2 & in_rs2[XLEN-1];
  assign w_abs1    = w_neg1 ? -in_rs1 : in_rs1;
  assign w_abs2    = w_neg2 ? -in_rs2 : in_rs2;
  // remainder takes the dividend sign, everything else the product of signs
  assign w_res_neg = (in_op[2] & in_op[1]) ? w_neg1 : (w_neg1 ^ w_neg2);

  assign w_div0    = in_op[2] && (in_rs2 == '0);
  assign w_ovf     = in_op[2] && !in_op[0] && (in_rs1 == MIN_INT) && (in_rs2 == '1);
  assign w_special = w_div0 || w_ovf;
  assign w_special_val = w_div0 ? (in_op[1] ? in_rs1 : '1)
                                : (in_op[1] ? '0 : MIN_INT);

  assign w_accept  = in_valid && (r_state == IDLE) && !flush;

  always_comb begin : step
    logic [XLEN:0]   w_part;
    logic [XLEN-1:0] w_lo;
    w_acc_nxt = r_acc;
    w_part    = '0;
    w_lo      = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_op[2]) begin
        // acc = {remainder, dividend bits not yet consumed / quotient bits}
        w_part = w_acc_nxt[2*XLEN-1:XLEN-1];
        w_lo   = {w_acc_nxt[XLEN-2:0], 1'b0};
        if (w_part >= {1'b0, r_d}) begin
          w_part  = w_part - {1'b0, r_d};
          w_lo[0] = 1'b1;
        end
        w_acc_nxt = {w_part[XLEN-1:0], w_lo};
      end else begin
        w_part    = {1'b0, w_acc_nxt[2*XLEN-1:XLEN]} + (w_acc_nxt[0] ? {1'b0, r_d} : '0);
        w_acc_nxt = {w_part, w_acc_nxt[XLEN-1:1]};
      end
    end
  end

  assign w_prod = r_neg ? -w_acc_nxt : w_acc_nxt;

  always_comb begin
    w_result = '0;
    case (r_op)
      3'b000:                 w_result = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_result = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_result = r_neg ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
      default:                w_result = r_neg ? -w_acc_nxt[2*XLEN-1:XLEN]
                                               : w_acc_nxt[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = w_special ? DONE : CALC;
      CALC:    if (r_cnt == CW'(1)) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_d      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_tag    <= '0;
    end else if (w_accept) begin
      r_op  <= in_op;
      r_tag <= in_tag;
      r_neg <= w_res_neg;
      r_d   <= in_op[2] ? w_abs2 : w_abs1;
      r_acc <= {{XLEN{1'b0}}, (in_op[2] ? w_abs1 : w_abs2)};
      r_cnt <= CW'(N);
      if (w_special) r_result <= w_special_val;
    end else if (r_state == CALC && !flush) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_result <= w_result;
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign busy       = (r_state != IDLE);
  assign out_result = r_result;
  assign out_tag    = r_tag;

endmodule
